vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 119 +++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: clk-to-pixel divider, h/v position counters, sync and strobe generation.
// Syncs and line/frame strobes are registered from next-state counters to stay aligned with them.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 2,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned CW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          p_tick,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [7:0]    fcnt_q, fcnt_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic          ls_q, ls_d, fs_q, fs_d;
    logic          tick, x_wrap, y_wrap;

    // Gated by rst so a single-clock divider does not strobe while held in reset.
    assign tick   = rst & en & (div_q == DIV_LAST);
    assign x_wrap = (x_q == H_LAST);
    assign y_wrap = (y_q == V_LAST);

    always_comb begin
        div_d  = div_q;
        x_d    = x_q;
        y_d    = y_q;
        fcnt_d = fcnt_q;
        ls_d   = 1'b0;
        fs_d   = 1'b0;
        if (tick) begin
            div_d = '0;
            ls_d  = x_wrap;
            if (x_wrap) begin
                x_d = '0;
                if (y_wrap) begin
                    y_d    = '0;
                    fs_d   = 1'b1;
                    fcnt_d = fcnt_q + 8'd1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end else if (en) begin
            div_d = div_q + 1'b1;
        end
        hsync_d = (x_d >= HS_FIRST && x_d <= HS_LAST) ? HS_POL : ~HS_POL;
        vsync_d = (y_d >= VS_FIRST && y_d <= VS_LAST) ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            fcnt_q  <= '0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fcnt_q  <= fcnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign p_tick      = tick;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_cnt   = fcnt_q;
    // Strobes drop immediately when en falls, even mid-pulse.
    assign line_start  = ls_q & en;
    assign frame_start = fs_q & en;
    assign video_on    = (x_q < H_VIS) && (y_q < V_VIS);

endmodule
